screen_dumper: RTL and testbench



---
 rtl/char_pkg.sv | 32 +++
 rtl/glyph_to_ascii.sv | 26 ++
 rtl/screen_dumper.sv | 152 +++++++++++++++
 tb/tb_screen_dumper.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared character-buffer definitions: screen geometry, glyph index ranges, ASCII codes, dump FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package char_pkg;

  // Screen geometry (COLS x ROWS must fit in an 8-bit cell address)
  localparam int COLS  = 20;
  localparam int ROWS  = 7;
  localparam int CELLS = COLS * ROWS;

  // Last glyph index of each contiguous glyph range
  localparam logic [7:0] GLYPH_DIGIT_END = 8'd9;    // '0'..'9'
  localparam logic [7:0] GLYPH_UPPER_END = 8'd35;   // 'A'..'Z'
  localparam logic [7:0] GLYPH_LOWER_END = 8'd61;   // 'a'..'z'
  localparam logic [7:0] GLYPH_EXT_END   = 8'd129;  // extended bytes 128..195
  localparam logic [7:0] GLYPH_CLEAR     = 8'hFF;   // cleared-cell marker written by the feeder

  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;     // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_EOL_CR,
    ST_EOL_LF,
    ST_FIN
  } dump_state_t;

endpackage

// File: rtl/glyph_to_ascii.sv
// Maps a stored glyph index back to the byte code the feeder received.
// Latency: combinational.
// Backpressure: none.
// Ports: glyph (8-bit glyph index in), ascii (8-bit byte code out).
// Indices past the extended range, including the clear marker, come back as '?'.
module glyph_to_ascii
  import char_pkg::*;
(
  input  logic [7:0] glyph,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_UNKNOWN;
    if (glyph <= GLYPH_DIGIT_END) begin
      ascii = glyph + 8'd48;
    end else if (glyph <= GLYPH_UPPER_END) begin
      ascii = glyph + 8'd55;
    end else if (glyph <= GLYPH_LOWER_END) begin
      ascii = glyph + 8'd61;
    end else if (glyph <= GLYPH_EXT_END) begin
      ascii = glyph + 8'd66;
    end
  end

endmodule

// File: rtl/screen_dumper.sv
// Streams the character buffer, row-major, to the UART as bytes; optional CR/LF after each row.
// Latency: start -> first tx_valid 2 cycles later; 3 cycles per cell (+1 per CR/LF) with tx_ready high, then one done cycle.
// Backpressure: holds tx_valid/tx_data stable in SEND/EOL states until tx_ready; each cell is read exactly once.
// Ports: clk, reset_n (sync active-low); start/busy/done control; mem_rd_en/mem_addr/mem_data buffer
//        read port (data one cycle after strobe); tx_data/tx_valid/tx_ready byte stream to the transmitter.
// Build option: define SCREEN_DUMPER_CRLF_EN to append 0x0D 0x0A after every row.
module screen_dumper
  import char_pkg::*;
#(
  parameter int COLS   = char_pkg::COLS,
  parameter int ROWS   = char_pkg::ROWS,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  dump_state_t      state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [7:0]       tx_byte, tx_byte_nxt;
  logic [7:0]       glyph_ascii;
  logic [ADDR_W-1:0] cell_addr;
  logic             last_col;
  logic             last_row;

  glyph_to_ascii u_glyph_to_ascii (
    .glyph (mem_data),
    .ascii (glyph_ascii)
  );

  assign cell_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  assign last_col  = (col == COL_W'(COLS - 1));
  assign last_row  = (row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      col     <= '0;
      row     <= '0;
      tx_byte <= '0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      tx_byte <= tx_byte_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    tx_byte_nxt = tx_byte;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;

    case (state)
      ST_IDLE: begin
        if (start) begin
          col_nxt   = '0;
          row_nxt   = '0;
          state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = cell_addr;
        state_nxt = ST_WAIT;
      end

      // Glyph arrives this cycle; latch its byte so it stays stable through any stall.
      ST_WAIT: begin
        tx_byte_nxt = glyph_ascii;
        state_nxt   = ST_SEND;
      end

      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
        if (tx_ready) begin
          if (!last_col) begin
            col_nxt   = col + 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            col_nxt = '0;
`ifdef SCREEN_DUMPER_CRLF_EN
            state_nxt = ST_EOL_CR;
`else
            if (last_row) begin
              state_nxt = ST_FIN;
            end else begin
              row_nxt   = row + 1'b1;
              state_nxt = ST_FETCH;
            end
`endif
          end
        end
      end

`ifdef SCREEN_DUMPER_CRLF_EN
      ST_EOL_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_CR;
        if (tx_ready) begin
          state_nxt = ST_EOL_LF;
        end
      end

      ST_EOL_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASCII_LF;
        if (tx_ready) begin
          if (last_row) begin
            state_nxt = ST_FIN;
          end else begin
            row_nxt   = row + 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
`endif

      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_screen_dumper.sv
// Randomized bench for screen_dumper with a queue-based byte model and a buffer model.
// Latency/backpressure of the DUT are checked from the outside: done timing, stall stability, single reads.
module tb_screen_dumper;

  localparam int COLS_T   = 20;
  localparam int ROWS_T   = 7;
  localparam int ADDR_W_T = 8;
  localparam int CELLS_T  = COLS_T * ROWS_T;
`ifdef SCREEN_DUMPER_CRLF_EN
  localparam int NBYTES = ROWS_T * (COLS_T + 2);
  localparam int WORK   = 3 * CELLS_T + 2 * ROWS_T;
`else
  localparam int NBYTES = CELLS_T;
  localparam int WORK   = 3 * CELLS_T;
`endif

  logic                clk;
  logic                reset_n;
  logic                start;
  logic                busy;
  logic                done;
  logic                mem_rd_en;
  logic [ADDR_W_T-1:0] mem_addr;
  logic [7:0]          mem_data;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  screen_dumper #(
    .COLS   (COLS_T),
    .ROWS   (ROWS_T),
    .ADDR_W (ADDR_W_T)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int ready_pct = 100;
  bit chk_en   = 1'b0;

  logic [7:0] mem [256];
  int         rd_cnt [256];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: synchronous read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data <= mem[mem_addr];
      rd_cnt[mem_addr] = rd_cnt[mem_addr] + 1;
    end
  end

  // Transmitter model: ready asserted with probability ready_pct percent.
  always @(posedge clk) begin
    #1;
    tx_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte the feeder originally received for a given glyph index.
  function automatic logic [7:0] ascii_of(input logic [7:0] g);
    string alnum;
    alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    if (g < 8'd62) return alnum[g];
    if (g < 8'd130) return 8'(int'(g) - 62 + 128);
    return 8'h3F;
  endfunction

  always @(negedge clk) if (done) done_cnt++;

  // Scoreboard: every accepted byte against the model; stalled bytes must not move.
  bit         stalled = 1'b0;
  logic [7:0] held    = 8'h00;
  always @(negedge clk) begin
    if (!chk_en || !reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(held));
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%02h, expected no more bytes", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      stalled = tx_valid && !tx_ready;
      held    = tx_data;
    end
  end

  task automatic build_expected();
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < ROWS_T; r++) begin
      for (int c = 0; c < COLS_T; c++) exp_q.push_back(ascii_of(mem[r * COLS_T + c]));
`ifdef SCREEN_DUMPER_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
    end
    for (int i = 0; i < 256; i++) rd_cnt[i] = 0;
  endtask

  task automatic run_dump(input int mid_start);
    int n_edge;
    int done_cyc;
    int db;
    bit seen;
    build_expected();
    db = done_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_edge = cyc;
    @(negedge clk);
    check("fetch_busy", 32'(busy), 32'd1);
    check("fetch_rd_en", 32'(mem_rd_en), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'd0);
    check("fetch_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("wait_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("first_tx_valid", 32'(tx_valid), 32'd1);
    seen = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      start = (mid_start > 0 && k == mid_start);
      if (done) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (ready_pct == 100) check("done_latency", 32'(done_cyc - n_edge), 32'(WORK));
    check("byte_count", 32'(got_q.size()), 32'(NBYTES));
    check("model_drained", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
    check("single_done", 32'(done_cnt - db), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int db;
    bit hit;
    string lit;
    reset_n = 1'b0;
    start   = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Ramp pattern, ready always high: exact timing and row-0 literal.
    for (int k = 0; k < CELLS_T; k++) mem[k] = 8'(k % 62);
    run_dump(0);
    lit = "0123456789ABCDEFGHIJ";
    for (int i = 0; i < 20; i++) check("row0_byte", 32'(got_q[i]), 32'(lit[i]));
`ifdef SCREEN_DUMPER_CRLF_EN
    check("row0_cr", 32'(got_q[20]), 32'h0D);
    check("row0_lf", 32'(got_q[21]), 32'h0A);
`endif

    // Range boundaries of the inverse map, random filler elsewhere.
    for (int k = 0; k < CELLS_T; k++) mem[k] = 8'($urandom_range(0, 255));
    mem[0] = 8'd62; mem[1] = 8'd128; mem[2] = 8'd129; mem[3] = 8'd130; mem[4] = 8'hFF;
    run_dump(0);
    check("glyph_62", 32'(got_q[0]), 32'd128);
    check("glyph_128", 32'(got_q[1]), 32'd194);
    check("glyph_129", 32'(got_q[2]), 32'd195);
    check("glyph_130", 32'(got_q[3]), 32'h3F);
    check("glyph_ff", 32'(got_q[4]), 32'h3F);

    // Heavy backpressure: same stream, no re-reads.
    ready_pct = 30;
    for (int k = 0; k < CELLS_T; k++) mem[k] = 8'($urandom_range(0, 255));
    run_dump(0);
    for (int k = 0; k < CELLS_T; k++) check("read_once", 32'(rd_cnt[k]), 32'd1);

    // Second start mid-dump is ignored.
    ready_pct = 70;
    for (int k = 0; k < CELLS_T; k++) mem[k] = 8'($urandom_range(0, 140));
    run_dump(50);

    // Reset during row 3 aborts without done; a fresh dump restarts at address 0.
    ready_pct = 100;
    chk_en = 1'b0;
    db = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 5000 && !hit; k++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr >= 8'(3 * COLS_T) && mem_addr < 8'(4 * COLS_T)) hit = 1'b1;
    end
    check("row3_reached", 32'(hit), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_en", 32'(mem_rd_en), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - db), 32'd0);
    chk_en = 1'b1;
    run_dump(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
